// File: rtl/led_mux_sequencer.sv
// led_mux_sequencer
//   Steps a 3-bit LED pattern select through 0..7. In run mode it advances automatically
//   every DWELL_CYCLES clocks. A debounced press of the step button also advances it.
//   The select drives a registered 6-bit pattern mux on led[7:2]. led[1] shows run mode,
//   and led[0] toggles on every advance.
//   Optional feature macro: LED_SEQ_REVERSE_EN. When it is defined, synced switch[6]=1
//   makes every advance decrement the select instead of incrementing it.
module led_mux_sequencer #(
    parameter int unsigned DWELL_CYCLES    = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] switch,
    input  logic       btn,
    output logic [7:0] led
);

    localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    logic               run_meta_q, run_s_q;
    logic               btn_meta_q, btn_s_q;
    logic               reverse;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               deb_level_q, deb_level_d;
    logic               step_q, step_d;
    state_e             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               hb_q, hb_d;
    logic               advance;
    logic [5:0]         pattern;
    logic [7:0]         led_q;

`ifdef LED_SEQ_REVERSE_EN
    logic dir_meta_q, dir_s_q;
    logic unused_switch;
    assign unused_switch = ^switch[5:0];
    assign reverse       = dir_s_q;

    // Two-flop synchronizer for the direction switch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_meta_q <= 1'b0;
            dir_s_q    <= 1'b0;
        end else begin
            dir_meta_q <= switch[6];
            dir_s_q    <= dir_meta_q;
        end
    end
`else
    logic unused_switch;
    assign unused_switch = ^switch[6:0];
    assign reverse       = 1'b0;
`endif

    // Two-flop synchronizers for run enable and the raw button
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values;
        // blocking would collapse the two synchronizer stages into one.
        if (rst) begin
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
        end else begin
            run_meta_q <= switch[7];
            run_s_q    <= run_meta_q;
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
        deb_cnt_d   = '0;
        deb_level_d = deb_level_q;
        step_d      = 1'b0;
        if (btn_s_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = btn_s_q;
                step_d      = btn_s_q;  // only a rising acceptance steps
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // FSM next state, dwell counter and select advance (at most one advance per cycle)
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dwell_d = dwell_q;
        hb_d    = hb_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                dwell_d = '0;
                advance = step_q;
                if (run_s_q) state_d = RUN;
            end
            RUN: begin
                if (!run_s_q) begin
                    state_d = IDLE;
                    dwell_d = '0;
                    advance = step_q;
                end else if (step_q || (dwell_q == DWELL_LAST)) begin
                    advance = 1'b1;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            sel_d = reverse ? (sel_q - 3'd1) : (sel_q + 3'd1);
            hb_d  = ~hb_q;
        end
    end

    // Pattern mux feeding the registered output stage
    always_comb begin
        pattern = sel_q[2] ? (sel_q[0] ? 6'b101010 : 6'b000000)
                           : (sel_q[1] ? 6'b101010 : 6'b111111);
    end

    // State, debounce and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_q   <= '0;
            deb_level_q <= 1'b0;
            step_q      <= 1'b0;
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            dwell_q     <= '0;
            hb_q        <= 1'b0;
            led_q       <= 8'b1111_1100;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            deb_level_q <= deb_level_d;
            step_q      <= step_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            dwell_q     <= dwell_d;
            hb_q        <= hb_d;
            led_q       <= {pattern, (state_q == RUN), hb_q};
        end
    end

    assign led = led_q;

endmodule
